// File: rtl/umi_fir_filter_reg_arb.sv
// Two-requester register-port arbiter: IDLE grants one request, ACCESS strobes the register port, RESP holds the response.
// Define UMI_FIR_FILTER_ARB_RR_EN for round-robin arbitration; the default is fixed priority (requester 0 first).
module umi_fir_filter_reg_arb #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    reg_write,
  output logic                    reg_read,
  output logic [ADDR_WIDTH-1:0]   reg_address,
  output logic [DATA_WIDTH-1:0]   reg_datain,
  input  logic [DATA_WIDTH-1:0]   reg_dataout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q;
  logic                    owner_q;
  logic                    write_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    reg_write_q;
  logic                    reg_read_q;
  logic [ADDR_WIDTH-1:0]   reg_address_q;
  logic [DATA_WIDTH-1:0]   reg_datain_q;

  logic                    accept;
  logic                    gnt_idx;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

`ifdef UMI_FIR_FILTER_ARB_RR_EN
  logic last_grant_q;

  // On contention alternate away from the previous winner; otherwise take whoever asks.
  always_comb begin
    gnt_idx = ~req_valid[0];
    if (&req_valid) gnt_idx = ~last_grant_q;
  end
`else
  always_comb begin
    gnt_idx = ~req_valid[0];
  end
`endif

  // Reset gates the combinational grant so req_ready is 0 for the whole reset window.
  assign accept    = nreset && (state_q == IDLE) && (|req_valid);
  assign req_ready = {gnt_idx, ~gnt_idx} & {2{accept}};

  always_comb begin
    sel_write = gnt_idx ? req_write[1] : req_write[0];
    sel_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_data  = gnt_idx ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      write_q       <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      reg_write_q   <= 1'b0;
      reg_read_q    <= 1'b0;
      reg_address_q <= '0;
      reg_datain_q  <= '0;
`ifdef UMI_FIR_FILTER_ARB_RR_EN
      last_grant_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q       <= gnt_idx;
            write_q       <= sel_write;
            reg_address_q <= sel_addr;
            reg_datain_q  <= sel_data;
            reg_write_q   <= sel_write;
            reg_read_q    <= ~sel_write;
`ifdef UMI_FIR_FILTER_ARB_RR_EN
            last_grant_q  <= gnt_idx;
`endif
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          // reg_dataout follows reg_address combinationally, so it is valid in this cycle.
          reg_write_q <= 1'b0;
          reg_read_q  <= 1'b0;
          rsp_data_q  <= write_q ? '0 : reg_dataout;
          rsp_valid_q <= {owner_q, ~owner_q};
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign reg_write   = reg_write_q;
  assign reg_read    = reg_read_q;
  assign reg_address = reg_address_q;
  assign reg_datain  = reg_datain_q;

endmodule

// File: tb/tb_umi_fir_filter_reg_arb.sv
// Scoreboard bench for umi_fir_filter_reg_arb: stimulus pushes expected responses, a monitor pops them on each handshake.
module tb_umi_fir_filter_reg_arb;
  localparam int AW = 2;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          nreset;
  logic [1:0]    req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0] rsp_data, reg_datain, reg_dataout;
  logic          reg_write, reg_read;
  logic [AW-1:0] reg_address;

  umi_fir_filter_reg_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .reg_write(reg_write), .reg_read(reg_read), .reg_address(reg_address),
    .reg_datain(reg_datain), .reg_dataout(reg_dataout)
  );

  always #5 clk = ~clk;

  // Register block: three registers, address 3 is unmapped and reads 0.
  logic [DW-1:0] regs [0:2] = '{default: '0};
  assign reg_dataout = (reg_address < 2'd3) ? regs[reg_address] : '0;
  always @(posedge clk) if (reg_write && reg_address < 2'd3) regs[reg_address] <= reg_datain;

  typedef struct { logic o; logic [DW-1:0] d; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nreset && (rsp_valid & rsp_ready) != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL mon_unexpected act=%0h exp=none", rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_owner", rsp_valid, mon_e.o ? 2'b10 : 2'b01);
        chk("mon_data", rsp_data, mon_e.d);
      end
    end
  end

  // Drive request i from the next cycle, wait for accept, then check strobe at N+1 and response at N+2.
  task automatic issue(input int i, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp, output int waited);
    logic got;
    rsp_t e;
    @(posedge clk); #1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    waited = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin got = 1'b1; break; end
      waited++;
    end
    chk("accept", req_ready, 2'b01 << i);
    if (got) begin
      e.o = i[0]; e.d = exp;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("strobe", {reg_write, reg_read}, {wr, ~wr});
    chk("reg_address", reg_address, a);
    if (wr) chk("reg_datain", reg_datain, d);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 2'b01 << i);
    chk("rsp_data", rsp_data, exp);
  endtask

  logic [1:0] exp_g [4];
  int w;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef UMI_FIR_FILTER_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    nreset = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
    rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_out", {req_ready, rsp_valid, reg_write, reg_read}, '0);
    chk("rst_regs", {rsp_data, reg_address}, '0);
    nreset = 1'b1;

    issue(0, 1'b1, 2'd1, 128'hA5, 128'h0, w);
    issue(1, 1'b1, 2'd1, 128'h1234, 128'h0, w);
    issue(1, 1'b0, 2'd1, 128'h0, 128'h1234, w);
    issue(0, 1'b0, 2'd1, 128'h0, 128'h1234, w);
    issue(1, 1'b1, 2'd2, 128'h5A5A, 128'h0, w);
    issue(0, 1'b1, 2'd3, 128'hFFFF, 128'h0, w);
    issue(0, 1'b0, 2'd3, 128'h0, 128'h0, w);

    // Backpressure with the sequencer waiting.
    @(posedge clk); #1; rsp_ready = 2'b00;
    issue(0, 1'b0, 2'd2, 128'h0, 128'h5A5A, w);
    req_write[1] = 1'b0; req_addr[AW +: AW] = 2'd1; req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 2'b01);
      chk("bp_data", rsp_data, 128'h5A5A);
      chk("bp_no_accept", req_ready, 2'b00);
    end
    @(posedge clk); #1; rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_release_cycle", req_ready, 2'b00);
    issue(1, 1'b0, 2'd1, 128'h0, 128'h1234, w);
    chk("bp_idle_next", w, 0);
    @(posedge clk); #1; rsp_ready = 2'b11;

    // Ack on the wrong bit must not complete the host response.
    @(posedge clk); #1; rsp_ready = 2'b10;
    issue(0, 1'b0, 2'd1, 128'h0, 128'h1234, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wrong_ack_hold", rsp_valid, 2'b01);
    end
    @(posedge clk); #1; rsp_ready = 2'b01;
    @(posedge clk); #1; rsp_ready = 2'b11;

    // Reset in the middle of ACCESS.
    @(posedge clk); #1;
    req_write[0] = 1'b1; req_addr[0 +: AW] = 2'd2; req_data[0 +: DW] = 128'h77; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("mid_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    chk("mid_access", reg_write, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_ctl", {req_ready, rsp_valid, reg_write, reg_read}, '0);
    chk("mid_rst_addr", reg_address, '0);
    chk("mid_rst_datain", reg_datain, '0);
    chk("mid_rst_rsp", rsp_data, '0);
    req_valid = '0;
    @(negedge clk); nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", {rsp_valid, reg_write}, '0);
    end
    chk("aborted_write", regs[2], 128'h5A5A);

    // Contention right after reset.
    @(posedge clk); #1;
    req_write = 2'b00; req_addr = {2'd2, 2'd0}; req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic got;
      rsp_t e;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin got = 1'b1; break; end
      end
      chk($sformatf("grant%0d", t), req_ready, exp_g[t]);
      if (got) begin
        e.o = req_ready[1];
        e.d = req_ready[1] ? 128'h5A5A : 128'h0;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1; req_valid = '0;
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/umi_fir_filter_reg_arb.md
UMI_FIR_FILTER_REG_ARB -- requirements
Module: umi_fir_filter_reg_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL set the register address width.
REQ-002 Parameter DATA_WIDTH, default 128, SHALL set the register data width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 nreset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  2  SHALL carry the per-requester access request; bit 0 is the host and bit 1 is the local sequencer.
REQ-006 req_write  input  2  SHALL select the operation per requester: 1 = write, 0 = read.
REQ-007 req_addr  input  2*ADDR_WIDTH  SHALL carry the per-requester address; slice i belongs to requester i.
REQ-008 req_data  input  2*DATA_WIDTH  SHALL carry the per-requester write data; slice i belongs to requester i.
REQ-009 req_ready  output  2  SHALL carry the per-requester accept strobe.
REQ-010 rsp_valid  output  2  SHALL carry the per-requester response valid.
REQ-011 rsp_ready  input  2  SHALL carry the per-requester response accept.
REQ-012 rsp_data  output  DATA_WIDTH  SHALL carry the shared response data.
REQ-013 reg_write and reg_read  output  1 each  SHALL be the register-port strobes.
REQ-014 reg_address  output  ADDR_WIDTH  SHALL carry the register-port address.
REQ-015 reg_datain  output  DATA_WIDTH  SHALL carry the register-port write data.
REQ-016 reg_dataout  input  DATA_WIDTH  SHALL carry the register-port read data, which is combinational from reg_address.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-018 IDLE behaviour:
- When any req_valid bit is set, select one winner and assert req_ready for that winner only, in the same cycle.
- Latch the winner's index, write flag, address and data.
- Move to ACCESS.
REQ-019 ACCESS SHALL last exactly one cycle:
- Drive reg_address and reg_datain from the latched values.
- Assert reg_write for a write, or reg_read for a read.
- For a read, capture reg_dataout into rsp_data; for a write, set rsp_data to 0.
- Move to RESP.
REQ-020 RESP SHALL hold rsp_valid[owner] high, with rsp_data stable, until rsp_ready[owner] is 1, then return to IDLE.
REQ-021 Latency: a request accepted in cycle N SHALL strobe the register port in N+1 and assert rsp_valid in N+2; the minimum spacing between accepts SHALL be 3 cycles.
REQ-022 req_ready SHALL be 0 in ACCESS and RESP; requests SHALL NOT be dropped, and requesters SHALL hold req_valid until accepted.
REQ-023 Outside ACCESS, reg_write and reg_read SHALL be 0; reg_address and reg_datain SHALL hold the last latched values.
REQ-024 rsp_ready on a non-owner bit, or any rsp_ready outside RESP, SHALL be ignored.
REQ-025 Out-of-range addresses SHALL be forwarded unchanged; the register block returns 0 for them.

Reset
REQ-026 Asserting nreset SHALL, asynchronously and at any time including mid-transaction, force:
- FSM to IDLE.
- req_ready, rsp_valid, reg_write and reg_read to 0.
- rsp_data, reg_address, reg_datain and all latches to 0.
- last_grant to 1.
REQ-027 A transaction interrupted by reset SHALL be abandoned, with no response; after deassertion the first IDLE cycle SHALL arbitrate normally.

Configuration
REQ-028 Macro UMI_FIR_FILTER_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With UMI_FIR_FILTER_ARB_RR_EN defined:
- Round-robin: when both requesters are valid, grant the requester not equal to last_grant.
- last_grant SHALL update on every accept.
- With reset value 1, requester 0 wins the first contention.
REQ-030 Without UMI_FIR_FILTER_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 highest; last_grant SHALL NOT be implemented.

Verification
REQ-031 Host write: req_valid=01, write=1, addr=1, data=0xA5 -> req_ready=01 in cycle N, reg_write=1 with address 1 and datain 0xA5 in N+1, rsp_valid=01 with rsp_data=0 in N+2.
REQ-032 Sequencer read: req_valid=10, addr=1, reg_dataout=0x1234 -> reg_read=1 in N+1, rsp_valid=10 with rsp_data=0x1234 in N+2.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stay stable, no new accept occurs, and the FSM enters IDLE the cycle after rsp_ready=1.
REQ-034 Contention: both requesters valid continuously for 4 transactions:
- With RR_EN, grant order is 0, 1, 0, 1.
- Without RR_EN, grant order is 0, 0, 0, 0.
REQ-035 Reset mid-ACCESS: assert nreset during the ACCESS cycle -> all outputs go to 0 immediately, and no rsp_valid appears after release.
REQ-036 Wrong-owner ack: owner=0 with rsp_ready=10 -> rsp_valid=01 is held until rsp_ready bit 0 is set.
